// File: rtl/crc_sig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_sig_pkg
// Brief    : Shared CRC-32/MISR signature definitions: polynomial, checker
//            state encoding and the single-step MISR update function.
// Revision : 1.0 - initial release
// ============================================================================
package crc_sig_pkg;

    localparam logic [31:0] CRC_POLY = 32'h0001_0811;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } chk_state_t;

    // Shift left with the outgoing MSB folded back through the tap mask.
    function automatic logic [31:0] misr_step(
        input logic [31:0] s,
        input logic [31:0] d,
        input logic [31:0] poly = CRC_POLY
    );
        logic [31:0] n;
        n[0] = s[31] ^ d[0];
        for (int i = 1; i < 32; i++) begin
            n[i] = s[i-1] ^ d[i] ^ (poly[i] & s[31]);
        end
        return n;
    endfunction

endpackage : crc_sig_pkg
`default_nettype wire

// File: rtl/crc32_misr_step.sv
`default_nettype none
// ============================================================================
// Module   : crc32_misr_step
// Brief    : Purely combinational single MISR step n = step(s, d).
// Revision : 1.0 - initial release
// ============================================================================
module crc32_misr_step
    import crc_sig_pkg::*;
#(
    parameter logic [31:0] POLY = CRC_POLY
) (
    input  logic [31:0] s,
    input  logic [31:0] d,
    output logic [31:0] n
);

    assign n = misr_step(s, d, POLY);

endmodule : crc32_misr_step
`default_nettype wire

// File: rtl/crc32_sig_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc32_sig_checker
// Brief    : Compacts a stream of 32-bit response words into a MISR signature
//            and reports PASS/FAIL against a golden value latched at START.
// Revision : 1.0 - initial release
// ============================================================================
module crc32_sig_checker
    import crc_sig_pkg::*;
#(
    parameter logic [31:0] POLY  = 32'h0001_0811,
    parameter logic [31:0] SEED  = 32'h0000_0000,
    parameter int          LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic [LEN_W-1:0] LEN,
    input  logic [31:0]      GOLDEN,
    input  logic             DIN_VALID,
    input  logic [31:0]      DIN,
    output logic             DIN_READY,
    output logic [31:0]      SIG,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             FAIL
);

    // State literals are package-scoped because the DONE port shadows the
    // wildcard-imported DONE state name.
    localparam logic [LEN_W-1:0] c_len_one  = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_len_zero = '0;

    chk_state_t       r_state;
    chk_state_t       w_state_nxt;
    logic [31:0]      r_sig;
    logic [31:0]      w_sig_nxt;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] w_rem_nxt;
    logic [31:0]      r_golden;
    logic [31:0]      w_golden_nxt;
    logic             r_pass;
    logic             w_pass_nxt;
    logic             r_fail;
    logic             w_fail_nxt;
    logic             w_handshake;
    logic [31:0]      w_sig_step;

    crc32_misr_step #(
        .POLY (POLY)
    ) u_step (
        .s (r_sig),
        .d (DIN),
        .n (w_sig_step)
    );

    // Ready is withheld in the ABORT cycle so the producer never sees a word
    // accepted that the checker then discards.
    assign DIN_READY   = (r_state == crc_sig_pkg::COMPACT) && !ABORT;
    assign w_handshake = DIN_VALID && DIN_READY;

    always_comb begin
        w_state_nxt  = r_state;
        w_sig_nxt    = r_sig;
        w_rem_nxt    = r_remaining;
        w_golden_nxt = r_golden;
        w_pass_nxt   = r_pass;
        w_fail_nxt   = r_fail;

        if (ABORT) begin
            w_state_nxt = crc_sig_pkg::IDLE;
            w_sig_nxt   = '0;
            w_rem_nxt   = '0;
            w_pass_nxt  = 1'b0;
            w_fail_nxt  = 1'b0;
        end else begin
            case (r_state)
                crc_sig_pkg::IDLE,
                crc_sig_pkg::DONE: begin
                    if (START) begin
                        w_sig_nxt    = SEED;
                        w_rem_nxt    = LEN;
                        w_golden_nxt = GOLDEN;
                        w_pass_nxt   = 1'b0;
                        w_fail_nxt   = 1'b0;
                        w_state_nxt  = (LEN == c_len_zero) ? crc_sig_pkg::CHECK
                                                           : crc_sig_pkg::COMPACT;
                    end
                end
                crc_sig_pkg::COMPACT: begin
                    if (w_handshake) begin
                        w_sig_nxt = w_sig_step;
                        w_rem_nxt = r_remaining - c_len_one;
                        if (r_remaining == c_len_one) begin
                            w_state_nxt = crc_sig_pkg::CHECK;
                        end
                    end
                end
                crc_sig_pkg::CHECK: begin
                    w_pass_nxt  = (r_sig == r_golden);
                    w_fail_nxt  = (r_sig != r_golden);
                    w_state_nxt = crc_sig_pkg::DONE;
                end
                default: begin
                    w_state_nxt = crc_sig_pkg::IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= crc_sig_pkg::IDLE;
            r_sig       <= '0;
            r_remaining <= '0;
            r_golden    <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sig       <= w_sig_nxt;
            r_remaining <= w_rem_nxt;
            r_golden    <= w_golden_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    assign SIG  = r_sig;
    assign BUSY = (r_state == crc_sig_pkg::COMPACT) || (r_state == crc_sig_pkg::CHECK);
    assign DONE = (r_state == crc_sig_pkg::DONE);
    assign PASS = r_pass;
    assign FAIL = r_fail;

endmodule : crc32_sig_checker
`default_nettype wire

// File: tb/tb_crc32_sig_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc32_sig_checker
// Brief    : Directed scoreboard bench for crc32_sig_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc32_sig_checker;

    localparam int LEN_W = 16;

    typedef struct {
        logic [31:0] sig;
        logic        pass;
        logic        fail;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] len;
    logic [31:0]      golden;
    logic             din_valid;
    logic [31:0]      din;
    logic             din_ready;
    logic [31:0]      sig;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic r_done_prev = 1'b0;

    crc32_sig_checker #(
        .POLY  (32'h0001_0811),
        .SEED  (32'h0000_0000),
        .LEN_W (LEN_W)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .START     (start),
        .ABORT     (abort),
        .LEN       (len),
        .GOLDEN    (golden),
        .DIN_VALID (din_valid),
        .DIN       (din),
        .DIN_READY (din_ready),
        .SIG       (sig),
        .BUSY      (busy),
        .DONE      (done),
        .PASS      (pass),
        .FAIL      (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising DONE retires one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && done && !r_done_prev) begin
            if (q_exp.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("result_sig",  sig,  e.sig);
                check("result_pass", {31'd0, pass}, {31'd0, e.pass});
                check("result_fail", {31'd0, fail}, {31'd0, e.fail});
            end
        end
        r_done_prev = done && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [LEN_W-1:0] l, input logic [31:0] g,
                             input logic expect_done, input exp_t e);
        start  = 1'b1;
        len    = l;
        golden = g;
        if (expect_done) q_exp.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        bit accepted = 1'b0;
        din_valid = 1'b1;
        din       = d;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = din_ready;
            tick();
        end
        din_valid = 1'b0;
        if (!accepted) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 10) begin
            tick();
            cyc++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    exp_t e;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0; golden = '0;
        din_valid = 1'b0; din = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_sig",   sig, 32'h0);
        check("reset_flags", {26'd0, busy, done, pass, fail, din_ready, 1'b0}, 32'h0);

        // LEN=1, single word 1 -> SIG=1, PASS two cycles after handshake
        e = '{sig: 32'h1, pass: 1'b1, fail: 1'b0};
        start_run(16'd1, 32'h1, 1'b1, e);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_word(32'h1);
        check("t1_sig_after_hs", sig, 32'h1);
        check("t1_not_done_yet", {31'd0, done}, 32'd0);
        tick();
        check("t1_done_latency", {30'd0, done, pass}, 32'd3);

        // Re-arm from DONE: PASS clears as SIG reloads
        e = '{sig: 32'h0001_0811, pass: 1'b1, fail: 1'b0};
        start_run(16'd2, 32'h0001_0811, 1'b1, e);
        check("t2_rearm_clear", {sig[30:0], done, pass}, 33'h0);
        send_word(32'h8000_0000);
        check("t2_sig_w1", sig, 32'h8000_0000);
        send_word(32'h0);
        check("t2_sig_w2", sig, 32'h0001_0811);
        wait_done();

        // Same stream, wrong golden
        e = '{sig: 32'h0001_0811, pass: 1'b0, fail: 1'b1};
        start_run(16'd2, 32'h0001_0810, 1'b1, e);
        send_word(32'h8000_0000);
        send_word(32'h0);
        wait_done();

        // Gap of 3 idle cycles between words
        e = '{sig: 32'h0001_0811, pass: 1'b1, fail: 1'b0};
        start_run(16'd2, 32'h0001_0811, 1'b1, e);
        send_word(32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_gap_hold", sig, 32'h8000_0000);
        end
        check("t4_gap_busy", {31'd0, busy}, 32'd1);
        send_word(32'h0);
        wait_done();

        // LEN=0 compares SEED to GOLDEN, no words accepted
        e = '{sig: 32'h0, pass: 1'b1, fail: 1'b0};
        start_run(16'd0, 32'h0, 1'b1, e);
        check("t5_ready_check", {31'd0, din_ready}, 32'd0);
        tick();
        check("t5_ready_done", {30'd0, din_ready, done}, 32'd1);

        // Three words 1,2,3 -> 1, 0, 3
        e = '{sig: 32'h3, pass: 1'b1, fail: 1'b0};
        start_run(16'd3, 32'h3, 1'b1, e);
        send_word(32'h1);
        send_word(32'h2);
        check("t6_sig_mid", sig, 32'h0);
        send_word(32'h3);
        wait_done();

        // START during COMPACT is ignored
        e = '{sig: 32'h0001_0811, pass: 1'b1, fail: 1'b0};
        start_run(16'd2, 32'h0001_0811, 1'b1, e);
        send_word(32'h8000_0000);
        start = 1'b1; len = 16'd0; golden = 32'h0;
        tick();
        start = 1'b0;
        check("t7_start_ignored", {sig[31:1], busy}, 32'h8000_0001);
        send_word(32'h0);
        wait_done();
        tick();

        // ABORT after 1 of 4 words, handshake in the abort cycle dropped
        start_run(16'd4, 32'h0, 1'b0, e);
        send_word(32'h1);
        abort = 1'b1; din_valid = 1'b1; din = 32'h5;
        tick();
        abort = 1'b0; din_valid = 1'b0;
        check("t8_abort_sig", sig, 32'h0);
        check("t8_abort_flags", {27'd0, busy, done, pass, fail, din_ready}, 32'h0);

        // RESET mid-COMPACT
        start_run(16'd4, 32'h0, 1'b0, e);
        send_word(32'h1);
        rst = 1'b1;
        tick();
        check("t9_reset_sig", sig, 32'h0);
        check("t9_reset_flags", {27'd0, busy, done, pass, fail, din_ready}, 32'h0);
        rst = 1'b0;
        tick();

        check("scoreboard_drained", q_exp.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_crc32_sig_checker
`default_nettype wire
